// File: rtl/debug_word_tx.sv
// debug_word_tx: serializes a TAM_DATA-bit debug word into TAM_ORDEN-bit bytes for the UART TX,
// one byte per byte-done tick, and pulses o_tx_done_32b_word when the whole word has gone out.
module debug_word_tx #(
   parameter int TAM_DATA  = 32,
   parameter int TAM_ORDEN = 8,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_enable_enviada_data,
   input  logic [TAM_DATA-1:0]  i_data_enviada,
   input  logic                 i_tx_done_tick,
   output logic                 o_tx_done_32b_word,
   output logic                 o_busy,
   output logic                 o_overrun,
   output logic                 o_tx_start,
   output logic [TAM_ORDEN-1:0] o_tx_byte
);
   // state   | meaning
   // ST_IDLE | waiting for a send request
   // ST_LOAD | one cycle: start pulse to the UART with the current byte
   // ST_WAIT | byte held on o_tx_byte until the UART byte-done tick
   // ST_DONE | one cycle: word-done pulse to the debug state machine
   localparam int NB = TAM_DATA / TAM_ORDEN;
   localparam int IW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WAIT, ST_DONE} state_t;

   state_t               state, state_nx;
   logic [IW-1:0]        idx, idx_nx;
   logic [TAM_DATA-1:0]  shreg, shreg_nx, shifted;
   logic [TAM_ORDEN-1:0] byte_nx;

   // The byte on the wire is always the leading end of the shift register.
   function automatic logic [TAM_ORDEN-1:0] head(input logic [TAM_DATA-1:0] w);
      if (MSB_FIRST)
         return w[TAM_DATA-1 -: TAM_ORDEN];
      else
         return w[TAM_ORDEN-1:0];
   endfunction

   assign shifted = MSB_FIRST ? (shreg << TAM_ORDEN) : (shreg >> TAM_ORDEN);

   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      shreg_nx = shreg;
      byte_nx  = o_tx_byte;
      case (state)
         ST_IDLE: begin
            if (i_enable_enviada_data) begin
               shreg_nx = i_data_enviada;
               idx_nx   = '0;
               byte_nx  = head(i_data_enviada);
               state_nx = ST_LOAD;
            end
         end
         ST_LOAD: state_nx = ST_WAIT;
         ST_WAIT: begin
            if (i_tx_done_tick) begin
               if (idx == LAST_IDX) begin
                  state_nx = ST_DONE;
               end else begin
                  idx_nx   = idx + IW'(1);
                  shreg_nx = shifted;
                  byte_nx  = head(shifted);
                  state_nx = ST_LOAD;
               end
            end
         end
         ST_DONE: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next-state decode so they line up with the state register.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state              <= ST_IDLE;
         idx                <= '0;
         shreg              <= '0;
         o_tx_start         <= 1'b0;
         o_tx_byte          <= '0;
         o_tx_done_32b_word <= 1'b0;
         o_busy             <= 1'b0;
         o_overrun          <= 1'b0;
      end else begin
         state              <= state_nx;
         idx                <= idx_nx;
         shreg              <= shreg_nx;
         o_tx_start         <= (state_nx == ST_LOAD);
         o_tx_byte          <= byte_nx;
         o_tx_done_32b_word <= (state_nx == ST_DONE);
         o_busy             <= (state_nx != ST_IDLE);
         o_overrun          <= i_enable_enviada_data && (state != ST_IDLE);
      end
   end

endmodule

// File: tb/tb_debug_word_tx.sv
// Bench for debug_word_tx: an LSB-first and an MSB-first instance driven in lockstep,
// checked against a byte-order model computed from the word with plain arithmetic.
module tb_debug_word_tx;
   localparam int TD = 32;
   localparam int TO = 8;
   localparam int NB = TD / TO;

   logic          i_clk   = 1'b0;
   logic          i_reset = 1'b1;
   logic          req     = 1'b0;
   logic          tick    = 1'b0;
   logic [TD-1:0] data    = '0;

   logic          start0, busy0, done0, ovr0;
   logic          start1, busy1, done1, ovr1;
   logic [TO-1:0] byte0, byte1;

   int n_checks = 0;
   int n_fail   = 0;
   int n_done0  = 0;
   int n_done1  = 0;
   int n_ovr0   = 0;
   int n_ovr1   = 0;
   logic [7:0] q0[$];
   logic [7:0] q1[$];

   always #5 i_clk = ~i_clk;

   debug_word_tx #(.TAM_DATA(TD), .TAM_ORDEN(TO), .MSB_FIRST(1'b0)) dut0 (
      .i_clk(i_clk), .i_reset(i_reset), .i_enable_enviada_data(req), .i_data_enviada(data),
      .i_tx_done_tick(tick), .o_tx_done_32b_word(done0), .o_busy(busy0), .o_overrun(ovr0),
      .o_tx_start(start0), .o_tx_byte(byte0));

   debug_word_tx #(.TAM_DATA(TD), .TAM_ORDEN(TO), .MSB_FIRST(1'b1)) dut1 (
      .i_clk(i_clk), .i_reset(i_reset), .i_enable_enviada_data(req), .i_data_enviada(data),
      .i_tx_done_tick(tick), .o_tx_done_32b_word(done1), .o_busy(busy1), .o_overrun(ovr1),
      .o_tx_start(start1), .o_tx_byte(byte1));

   // Record every byte started and every pulse, sampled mid-cycle.
   always @(negedge i_clk) begin
      if (start0) q0.push_back(byte0);
      if (start1) q1.push_back(byte1);
      if (done0) n_done0++;
      if (done1) n_done1++;
      if (ovr0) n_ovr0++;
      if (ovr1) n_ovr1++;
   end

   function automatic logic [7:0] exp_byte(input logic [31:0] w, input int k, input bit msb);
      int pos;
      pos = msb ? (NB - 1 - k) : k;
      return 8'((w >> (8 * pos)) & 32'hFF);
   endfunction

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   // UART-side responder: request pulse, then one tick per start after `gap` WAIT cycles.
   task automatic drive_word(input logic [31:0] word, input int gap, input bit spurious,
                             input bit scramble, input int ovr_k,
                             output int first_wait, output bit done_seen,
                             output bit busy_after, output bit ovr_seen, output bit timeout);
      int w;
      timeout    = 1'b0;
      ovr_seen   = 1'b0;
      done_seen  = 1'b0;
      busy_after = 1'b1;
      first_wait = -1;
      req  = 1'b1;
      data = word;
      step();
      req = 1'b0;
      if (scramble) data = 32'hFFFF_FFFF;
      for (int k = 0; k < NB; k++) begin
         w = 0;
         while (!start0 && w < 100) begin
            step();
            w++;
         end
         if (w >= 100) begin
            timeout = 1'b1;
            return;
         end
         if (k == 0) first_wait = w;
         if (spurious) tick = 1'b1;
         step();
         tick = 1'b0;
         if (k == ovr_k) begin
            req = 1'b1;
            step();
            req = 1'b0;
            ovr_seen = ovr0 && ovr1;
            w = 1;
         end else begin
            w = 0;
         end
         for (; w < gap; w++) step();
         tick = 1'b1;
         step();
         tick = 1'b0;
      end
      done_seen = done0 && done1;
      step();
      busy_after = busy0 || busy1 || done0 || done1;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge i_clk);
      #1;
      n_checks++;
      if ({start0, busy0, done0, ovr0, byte0} !== '0) begin
         n_fail++;
         $display("FAIL reset_dut0: got %b want all zero", {start0, busy0, done0, ovr0, byte0});
      end
      n_checks++;
      if ({start1, busy1, done1, ovr1, byte1} !== '0) begin
         n_fail++;
         $display("FAIL reset_dut1: got %b want all zero", {start1, busy1, done1, ovr1, byte1});
      end
      i_reset = 1'b0;
      step();
      n_checks++;
      if (busy0 !== 1'b0 || start0 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: busy=%b start=%b want 0 0", busy0, start0);
      end
   endtask

   task automatic test_byte_order();
      int b0, b1, d0, d1, fw;
      bit ds, ba, os, to;
      b0 = q0.size(); b1 = q1.size(); d0 = n_done0; d1 = n_done1;
      drive_word(32'hDEADBEEF, 9, 1'b0, 1'b0, -1, fw, ds, ba, os, to);
      n_checks++;
      if (to) begin n_fail++; $display("FAIL order_timeout: got timeout want none"); end
      n_checks++;
      if (fw != 0) begin n_fail++; $display("FAIL order_latency: got %0d want 0", fw); end
      n_checks++;
      if (q0.size() - b0 != NB || q1.size() - b1 != NB) begin
         n_fail++;
         $display("FAIL order_starts: got %0d/%0d want %0d", q0.size() - b0, q1.size() - b1, NB);
      end
      for (int k = 0; k < NB; k++) begin
         n_checks++;
         if (b0 + k >= q0.size() || q0[b0 + k] !== exp_byte(32'hDEADBEEF, k, 1'b0)) begin
            n_fail++;
            $display("FAIL order_lsb_byte%0d: got %h want %h", k,
                     (b0 + k < q0.size()) ? q0[b0 + k] : 8'hxx, exp_byte(32'hDEADBEEF, k, 1'b0));
         end
         n_checks++;
         if (b1 + k >= q1.size() || q1[b1 + k] !== exp_byte(32'hDEADBEEF, k, 1'b1)) begin
            n_fail++;
            $display("FAIL order_msb_byte%0d: got %h want %h", k,
                     (b1 + k < q1.size()) ? q1[b1 + k] : 8'hxx, exp_byte(32'hDEADBEEF, k, 1'b1));
         end
      end
      n_checks++;
      if (!ds) begin n_fail++; $display("FAIL order_done: got 0 want 1 one cycle after last tick"); end
      n_checks++;
      if (n_done0 - d0 != 1 || n_done1 - d1 != 1) begin
         n_fail++;
         $display("FAIL order_done_count: got %0d/%0d want 1", n_done0 - d0, n_done1 - d1);
      end
      n_checks++;
      if (ba) begin n_fail++; $display("FAIL order_busy_after: got 1 want 0"); end
   endtask

   task automatic test_immunity();
      int b0, b1, fw;
      bit ds, ba, os, to;
      tick = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if (start0 !== 1'b0 || busy0 !== 1'b0 || start1 !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_tick: start=%b busy=%b want 0 0", start0, busy0);
         end
      end
      tick = 1'b0;
      b0 = q0.size(); b1 = q1.size();
      drive_word(32'h0000_0001, int'($urandom_range(1, 5)), 1'b1, 1'b1, -1, fw, ds, ba, os, to);
      data = '0;
      n_checks++;
      if (to || !ds) begin n_fail++; $display("FAIL immune_complete: timeout=%b done=%b want 0 1", to, ds); end
      n_checks++;
      if (q0.size() - b0 != NB || q1.size() - b1 != NB) begin
         n_fail++;
         $display("FAIL immune_starts: got %0d/%0d want %0d", q0.size() - b0, q1.size() - b1, NB);
      end
      for (int k = 0; k < NB; k++) begin
         n_checks++;
         if (b0 + k >= q0.size() || b1 + k >= q1.size() ||
             q0[b0 + k] !== exp_byte(32'h1, k, 1'b0) || q1[b1 + k] !== exp_byte(32'h1, k, 1'b1)) begin
            n_fail++;
            $display("FAIL immune_byte%0d: got %h/%h want %h/%h", k,
                     (b0 + k < q0.size()) ? q0[b0 + k] : 8'hxx, (b1 + k < q1.size()) ? q1[b1 + k] : 8'hxx,
                     exp_byte(32'h1, k, 1'b0), exp_byte(32'h1, k, 1'b1));
         end
      end
   endtask

   task automatic test_overrun();
      int b0, o0, o1, d0, fw;
      bit ds, ba, os, to;
      logic [31:0] w;
      w = $urandom;
      b0 = q0.size(); o0 = n_ovr0; o1 = n_ovr1; d0 = n_done0;
      drive_word(w, 4, 1'b0, 1'b0, 2, fw, ds, ba, os, to);
      n_checks++;
      if (!os) begin n_fail++; $display("FAIL overrun_pulse: got 0 want 1 the cycle after request"); end
      n_checks++;
      if (n_ovr0 - o0 != 1 || n_ovr1 - o1 != 1) begin
         n_fail++;
         $display("FAIL overrun_count: got %0d/%0d want 1", n_ovr0 - o0, n_ovr1 - o1);
      end
      n_checks++;
      if (to || !ds || n_done0 - d0 != 1) begin
         n_fail++;
         $display("FAIL overrun_complete: timeout=%b done=%b count=%0d want 0 1 1", to, ds, n_done0 - d0);
      end
      n_checks++;
      if (q0.size() - b0 != NB) begin
         n_fail++;
         $display("FAIL overrun_starts: got %0d want %0d", q0.size() - b0, NB);
      end
      for (int k = 0; k < NB; k++) begin
         n_checks++;
         if (b0 + k >= q0.size() || q0[b0 + k] !== exp_byte(w, k, 1'b0)) begin
            n_fail++;
            $display("FAIL overrun_byte%0d: got %h want %h", k,
                     (b0 + k < q0.size()) ? q0[b0 + k] : 8'hxx, exp_byte(w, k, 1'b0));
         end
      end
   endtask

   task automatic test_back_to_back();
      int b1, fw;
      bit ds, ba, os, to;
      logic [31:0] w1, w2;
      w1 = $urandom; w2 = $urandom;
      b1 = q1.size();
      drive_word(w1, 0, 1'b0, 1'b0, -1, fw, ds, ba, os, to);
      drive_word(w2, 0, 1'b0, 1'b0, -1, fw, ds, ba, os, to);
      n_checks++;
      if (to || fw != 0) begin
         n_fail++;
         $display("FAIL b2b_latency: got %0d want 0 (timeout=%b)", fw, to);
      end
      n_checks++;
      if (q1.size() - b1 != 2 * NB) begin
         n_fail++;
         $display("FAIL b2b_starts: got %0d want %0d", q1.size() - b1, 2 * NB);
      end
      for (int k = 0; k < 2 * NB; k++) begin
         n_checks++;
         if (b1 + k >= q1.size() ||
             q1[b1 + k] !== exp_byte((k < NB) ? w1 : w2, k % NB, 1'b1)) begin
            n_fail++;
            $display("FAIL b2b_byte%0d: got %h want %h", k, (b1 + k < q1.size()) ? q1[b1 + k] : 8'hxx,
                     exp_byte((k < NB) ? w1 : w2, k % NB, 1'b1));
         end
      end
   endtask

   task automatic test_reset_abort();
      int b0, d0, fw;
      bit ds, ba, os, to;
      b0 = q0.size(); d0 = n_done0;
      req = 1'b1; data = 32'h0BAD_F00D;
      step();
      req = 1'b0;
      step();
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
      step();
      #2 i_reset = 1'b1;
      #1;
      n_checks++;
      if ({start0, busy0, done0, ovr0, byte0} !== '0 || {start1, busy1, done1, ovr1, byte1} !== '0) begin
         n_fail++;
         $display("FAIL abort_outputs: got %b / %b want all zero",
                  {start0, busy0, done0, ovr0, byte0}, {start1, busy1, done1, ovr1, byte1});
      end
      step();
      i_reset = 1'b0;
      repeat (20) step();
      n_checks++;
      if (n_done0 != d0 || q0.size() - b0 != 2) begin
         n_fail++;
         $display("FAIL abort_quiet: done=%0d starts=%0d want 0 2", n_done0 - d0, q0.size() - b0);
      end
      b0 = q0.size(); d0 = n_done0;
      drive_word(32'h1234_5678, 3, 1'b0, 1'b0, -1, fw, ds, ba, os, to);
      n_checks++;
      if (to || !ds || ba || n_done0 - d0 != 1) begin
         n_fail++;
         $display("FAIL abort_recover: timeout=%b done=%b busy=%b want 0 1 0", to, ds, ba);
      end
      for (int k = 0; k < NB; k++) begin
         n_checks++;
         if (b0 + k >= q0.size() || q0[b0 + k] !== exp_byte(32'h1234_5678, k, 1'b0)) begin
            n_fail++;
            $display("FAIL abort_byte%0d: got %h want %h", k,
                     (b0 + k < q0.size()) ? q0[b0 + k] : 8'hxx, exp_byte(32'h1234_5678, k, 1'b0));
         end
      end
   endtask

   task automatic test_random();
      int b0, b1, d1, fw;
      bit ds, ba, os, to;
      logic [31:0] w;
      for (int n = 0; n < 8; n++) begin
         w = $urandom;
         b0 = q0.size(); b1 = q1.size(); d1 = n_done1;
         drive_word(w, int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), 1'b1, -1,
                    fw, ds, ba, os, to);
         n_checks++;
         if (to || !ds || ba || n_done1 - d1 != 1) begin
            n_fail++;
            $display("FAIL rand%0d_complete: timeout=%b done=%b busy=%b want 0 1 0", n, to, ds, ba);
         end
         for (int k = 0; k < NB; k++) begin
            n_checks++;
            if (b0 + k >= q0.size() || b1 + k >= q1.size() ||
                q0[b0 + k] !== exp_byte(w, k, 1'b0) || q1[b1 + k] !== exp_byte(w, k, 1'b1)) begin
               n_fail++;
               $display("FAIL rand%0d_byte%0d: got %h/%h want %h/%h", n, k,
                        (b0 + k < q0.size()) ? q0[b0 + k] : 8'hxx, (b1 + k < q1.size()) ? q1[b1 + k] : 8'hxx,
                        exp_byte(w, k, 1'b0), exp_byte(w, k, 1'b1));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_byte_order();
      test_immunity();
      test_overrun();
      test_back_to_back();
      test_reset_abort();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
